// File: rtl/dart_turn_scheduler.sv
// dart_turn_scheduler: buffers board hits and issues them one at a time to the scoring core.
// Optional DART_TIMEOUT_EN: injects a (0,0) miss after TIMEOUT_CYC idle cycles with an empty buffer.
module dart_turn_scheduler #(
    parameter int DARTS_PER_TURN = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYC    = 1000,
    parameter int MAX_ROUNDS     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit_valid_i,
    output logic       hit_ready_o,
    input  logic [7:0] hit_x_i,
    input  logic [7:0] hit_y_i,
    output logic       dart_come_o,
    output logic [7:0] dart_x_o,
    output logic [7:0] dart_y_o,
    input  logic       p1_done_i,
    input  logic       p2_done_i,
    input  logic       game_set_i,
    output logic       cur_player_o,
    output logic [1:0] dart_idx_o,
    output logic [4:0] round_o,
    output logic       miss_o,
    output logic       err_o,
    output logic       draw_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, FINISH, DRAW} state_t;

    state_t      state;
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        terminal;
    logic        exp_done;
    logic        bad_done;
    logic        gs_seen;
    logic [7:0]  store_x;
    logic [7:0]  store_y;

    assign terminal    = (state == FINISH) || (state == DRAW);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign hit_ready_o = reset && !full && !terminal;
    assign push        = hit_valid_i && hit_ready_o;
    assign exp_done    = cur_player_o ? p2_done_i : p1_done_i;
    assign bad_done    = cur_player_o ? p1_done_i : p2_done_i;

    // Off-board hits are stored as (0,0) so they score nothing.
    always_comb begin
        store_x = hit_x_i;
        store_y = hit_y_i;
        if ((hit_x_i > 8'd30) || (hit_y_i > 8'd30)) begin
            store_x = '0;
            store_y = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= {store_x, store_y};
            wr_ptr              <= wr_ptr + 1'b1;
        end
    end

`ifdef DART_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tmo_cnt;
    logic          miss_q;
    assign miss_o = miss_q;
`else
    assign miss_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            dart_come_o  <= 1'b0;
            dart_x_o     <= '0;
            dart_y_o     <= '0;
            cur_player_o <= 1'b0;
            dart_idx_o   <= '0;
            round_o      <= '0;
            err_o        <= 1'b0;
            draw_o       <= 1'b0;
            gs_seen      <= 1'b0;
`ifdef DART_TIMEOUT_EN
            tmo_cnt      <= '0;
            miss_q       <= 1'b0;
`endif
        end else begin
            dart_come_o <= 1'b0;
`ifdef DART_TIMEOUT_EN
            miss_q      <= 1'b0;
`endif
            if ((state != WAIT) && (p1_done_i || p2_done_i))
                err_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {dart_x_o, dart_y_o} <= mem[rd_ptr[AW-1:0]];
                        rd_ptr               <= rd_ptr + 1'b1;
                        dart_come_o          <= 1'b1;
                        state                <= ISSUE;
`ifdef DART_TIMEOUT_EN
                        tmo_cnt              <= '0;
`endif
                    end
`ifdef DART_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        dart_x_o    <= '0;
                        dart_y_o    <= '0;
                        dart_come_o <= 1'b1;
                        miss_q      <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ISSUE;
                    end else if (push) begin
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (game_set_i)
                        gs_seen <= 1'b1;
                    if (bad_done)
                        err_o <= 1'b1;
                    if (exp_done)
                        state <= ADVANCE;
                end
                ADVANCE: begin
                    if (game_set_i)
                        gs_seen <= 1'b1;
                    // A winner outranks both the turn update and a draw.
                    if (gs_seen || game_set_i) begin
                        state <= FINISH;
                    end else if (dart_idx_o == 2'(DARTS_PER_TURN - 1)) begin
                        dart_idx_o   <= '0;
                        cur_player_o <= ~cur_player_o;
                        if (cur_player_o) begin
                            if (({1'b0, round_o} + 6'd1) >= 6'(MAX_ROUNDS)) begin
                                round_o <= 5'(MAX_ROUNDS);
                                draw_o  <= 1'b1;
                                state   <= DRAW;
                            end else begin
                                round_o <= round_o + 5'd1;
                                state   <= IDLE;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dart_idx_o <= dart_idx_o + 2'd1;
                        state      <= IDLE;
                    end
                end
                FINISH:  state <= FINISH;
                DRAW:    state <= DRAW;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dart_turn_scheduler.sv
// Directed self-checking bench for dart_turn_scheduler; a MAX_ROUNDS=1 twin shares the stimulus.
module tb_dart_turn_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       hit_valid;
    logic [7:0] hit_x;
    logic [7:0] hit_y;
    logic       p1_done;
    logic       p2_done;
    logic       game_set;

    logic       hit_ready, dart_come, cur_player, miss, err, draw;
    logic [7:0] dart_x, dart_y;
    logic [1:0] dart_idx;
    logic [4:0] round_n;

    logic       hit_ready2, dart_come2, cur_player2, miss2, err2, draw2;
    logic [7:0] dart_x2, dart_y2;
    logic [1:0] dart_idx2;
    logic [4:0] round2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dart_turn_scheduler #(.DARTS_PER_TURN(3), .FIFO_DEPTH(4), .TIMEOUT_CYC(1000), .MAX_ROUNDS(20)) dut (
        .clk(clk), .reset(reset), .hit_valid_i(hit_valid), .hit_ready_o(hit_ready),
        .hit_x_i(hit_x), .hit_y_i(hit_y), .dart_come_o(dart_come), .dart_x_o(dart_x),
        .dart_y_o(dart_y), .p1_done_i(p1_done), .p2_done_i(p2_done), .game_set_i(game_set),
        .cur_player_o(cur_player), .dart_idx_o(dart_idx), .round_o(round_n), .miss_o(miss),
        .err_o(err), .draw_o(draw)
    );

    dart_turn_scheduler #(.DARTS_PER_TURN(3), .FIFO_DEPTH(4), .TIMEOUT_CYC(1000), .MAX_ROUNDS(1)) dut_draw (
        .clk(clk), .reset(reset), .hit_valid_i(hit_valid), .hit_ready_o(hit_ready2),
        .hit_x_i(hit_x), .hit_y_i(hit_y), .dart_come_o(dart_come2), .dart_x_o(dart_x2),
        .dart_y_o(dart_y2), .p1_done_i(p1_done), .p2_done_i(p2_done), .game_set_i(game_set),
        .cur_player_o(cur_player2), .dart_idx_o(dart_idx2), .round_o(round2), .miss_o(miss2),
        .err_o(err2), .draw_o(draw2)
    );

`ifdef DART_TIMEOUT_EN
    logic       hit_ready3, dart_come3, cur_player3, miss3, err3, draw3;
    logic [7:0] dart_x3, dart_y3;
    logic [1:0] dart_idx3;
    logic [4:0] round3;

    dart_turn_scheduler #(.DARTS_PER_TURN(3), .FIFO_DEPTH(4), .TIMEOUT_CYC(8), .MAX_ROUNDS(20)) dut_tmo (
        .clk(clk), .reset(reset), .hit_valid_i(hit_valid), .hit_ready_o(hit_ready3),
        .hit_x_i(hit_x), .hit_y_i(hit_y), .dart_come_o(dart_come3), .dart_x_o(dart_x3),
        .dart_y_o(dart_y3), .p1_done_i(p1_done), .p2_done_i(p2_done), .game_set_i(game_set),
        .cur_player_o(cur_player3), .dart_idx_o(dart_idx3), .round_o(round3), .miss_o(miss3),
        .err_o(err3), .draw_o(draw3)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        hit_valid = 1'b0;
        hit_x     = '0;
        hit_y     = '0;
        p1_done   = 1'b0;
        p2_done   = 1'b0;
        game_set  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y);
        hit_valid = 1'b1;
        hit_x     = x;
        hit_y     = y;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic wait_come(input string name);
        bit got = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dart_come === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL %s: dart_come_o not seen within 20 cycles (got 0, need 1)", name);
        end
    endtask

    // Called in the ISSUE cycle; leaves the bench just after the ADVANCE update.
    task automatic serve(input bit p2, input bit gs);
        tick();
        p1_done  = !p2;
        p2_done  = p2;
        game_set = gs;
        tick();
        p1_done  = 1'b0;
        p2_done  = 1'b0;
        game_set = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [40:0] got;
        reset = 1'b0;
        hit_valid = 1'b0; hit_x = '0; hit_y = '0;
        p1_done = 1'b0; p2_done = 1'b0; game_set = 1'b0;
        tick();
        tick();
        got = {hit_ready, dart_come, dart_x, dart_y, cur_player, dart_idx, round_n, miss, err, draw, 9'd0};
        checks++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, need 0", got);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (hit_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, need 1", hit_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dart_come !== 1'b0) begin
                fails++;
                $display("FAIL idle_no_pulse: cycle %0d got %b, need 0", i, dart_come);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        push(8'd5, 8'd5);
        checks++;
        if (dart_come !== 1'b0) begin
            fails++;
            $display("FAIL single_early: dart_come_o got %b one cycle after push, need 0", dart_come);
        end
        tick();
        checks++;
        if ({dart_come, dart_x, dart_y} !== {1'b1, 8'd5, 8'd5}) begin
            fails++;
            $display("FAIL single_pulse: come/x/y got %b/%0d/%0d, need 1/5/5", dart_come, dart_x, dart_y);
        end
        tick();
        checks++;
        if (dart_come !== 1'b0) begin
            fails++;
            $display("FAIL single_one_cycle: dart_come_o got %b, need 0", dart_come);
        end
        repeat (3) tick();
        checks++;
        if ({dart_x, dart_y, dart_idx} !== {8'd5, 8'd5, 2'd0}) begin
            fails++;
            $display("FAIL single_hold: x/y/idx got %0d/%0d/%0d, need 5/5/0", dart_x, dart_y, dart_idx);
        end
        p1_done = 1'b1;
        tick();
        p1_done = 1'b0;
        tick();
        checks++;
        if ({dart_idx, cur_player, err} !== {2'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL single_done: idx/player/err got %0d/%b/%b, need 1/0/0", dart_idx, cur_player, err);
        end
    endtask

    task automatic test_turns();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(8'(i + 1), 8'(i + 2));
            wait_come("turn_p1");
            serve(1'b0, 1'b0);
        end
        checks++;
        if ({cur_player, dart_idx, round_n} !== {1'b1, 2'd0, 5'd0}) begin
            fails++;
            $display("FAIL turn_toggle: player/idx/round got %b/%0d/%0d, need 1/0/0", cur_player, dart_idx, round_n);
        end
        for (int i = 0; i < 3; i++) begin
            push(8'(i + 10), 8'(i + 11));
            wait_come("turn_p2");
            serve(1'b1, 1'b0);
        end
        checks++;
        if ({cur_player, dart_idx, round_n, err, draw} !== {1'b0, 2'd0, 5'd1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL round_one: player/idx/round/err/draw got %b/%0d/%0d/%b/%b, need 0/0/1/0/0",
                     cur_player, dart_idx, round_n, err, draw);
        end
        checks++;
        if ({draw2, round2, hit_ready2} !== {1'b1, 5'd1, 1'b0}) begin
            fails++;
            $display("FAIL draw_max1: draw/round/ready got %b/%0d/%b, need 1/1/0", draw2, round2, hit_ready2);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic exp_ready;
        do_reset();
        push(8'd9, 8'd9);
        wait_come("b2b_first");
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_ready = (i < 4);
            hit_valid = 1'b1;
            hit_x     = 8'(i + 1);
            hit_y     = 8'(i + 1);
            checks++;
            if (hit_ready !== exp_ready) begin
                fails++;
                $display("FAIL b2b_ready: hit %0d got %b, need %b", i, hit_ready, exp_ready);
            end
            tick();
            if (dart_come === 1'b1) pulses++;
        end
        hit_valid = 1'b0;
        repeat (3) begin
            tick();
            if (dart_come === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL b2b_no_extra_pulse: got %0d pulses, need 0", pulses);
        end
        p1_done = 1'b1;
        tick();
        p1_done = 1'b0;
        wait_come("b2b_next");
        checks++;
        if ({dart_x, dart_y} !== {8'd1, 8'd1}) begin
            fails++;
            $display("FAIL b2b_order: x/y got %0d/%0d, need 1/1", dart_x, dart_y);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        push(8'd40, 8'd3);
        wait_come("clamp_come");
        checks++;
        if ({dart_x, dart_y} !== 16'd0) begin
            fails++;
            $display("FAIL clamp_off_board: x/y got %0d/%0d, need 0/0", dart_x, dart_y);
        end
        serve(1'b0, 1'b0);
        push(8'd30, 8'd30);
        wait_come("edge_come");
        checks++;
        if ({dart_x, dart_y} !== {8'd30, 8'd30}) begin
            fails++;
            $display("FAIL clamp_edge30: x/y got %0d/%0d, need 30/30", dart_x, dart_y);
        end
    endtask

    task automatic test_wrong_player();
        do_reset();
        push(8'd7, 8'd8);
        wait_come("wrong_come");
        tick();
        p2_done = 1'b1;
        tick();
        p2_done = 1'b0;
        tick();
        checks++;
        if ({err, dart_idx, dart_x, dart_come} !== {1'b1, 2'd0, 8'd7, 1'b0}) begin
            fails++;
            $display("FAIL wrong_player: err/idx/x/come got %b/%0d/%0d/%b, need 1/0/7/0", err, dart_idx, dart_x, dart_come);
        end
        p1_done = 1'b1;
        tick();
        p1_done = 1'b0;
        tick();
        checks++;
        if ({err, dart_idx} !== {1'b1, 2'd1}) begin
            fails++;
            $display("FAIL err_sticky: err/idx got %b/%0d, need 1/1", err, dart_idx);
        end
        do_reset();
        tick();
        p1_done = 1'b1;
        tick();
        p1_done = 1'b0;
        tick();
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL done_in_idle: err got %b, need 1", err);
        end
    endtask

    task automatic test_game_set();
        int pulses = 0;
        do_reset();
        push(8'd4, 8'd4);
        wait_come("gs_come");
        serve(1'b0, 1'b1);
        checks++;
        if ({hit_ready, dart_idx, draw} !== {1'b0, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL game_set_finish: ready/idx/draw got %b/%0d/%b, need 0/0/0", hit_ready, dart_idx, draw);
        end
        hit_valid = 1'b1;
        hit_x = 8'd2;
        hit_y = 8'd2;
        repeat (5) begin
            tick();
            if (dart_come === 1'b1) pulses++;
        end
        hit_valid = 1'b0;
        checks++;
        if ((pulses != 0) || (hit_ready !== 1'b0)) begin
            fails++;
            $display("FAIL finish_frozen: pulses/ready got %0d/%b, need 0/0", pulses, hit_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(8'd6, 8'd6);
        wait_come("mid_come");
        serve(1'b0, 1'b0);
        push(8'd12, 8'd13);
        wait_come("mid_come2");
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({dart_x, dart_y, dart_idx, hit_ready, dart_come} !== 21'd0) begin
            fails++;
            $display("FAIL reset_mid_turn: x/y/idx/ready/come got %0d/%0d/%0d/%b/%b, need 0/0/0/0/0",
                     dart_x, dart_y, dart_idx, hit_ready, dart_come);
        end
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (dart_come !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abandon: dart_come_o got %b, need 0", dart_come);
        end
    endtask

`ifdef DART_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ((miss3 !== 1'b0) || (dart_come3 !== 1'b0)) begin
                fails++;
                $display("FAIL timeout_early: cycle %0d miss/come got %b/%b, need 0/0", i, miss3, dart_come3);
            end
        end
        tick();
        checks++;
        if ({miss3, dart_come3, dart_x3, dart_y3} !== {1'b1, 1'b1, 16'd0}) begin
            fails++;
            $display("FAIL timeout_miss: miss/come/x/y got %b/%b/%0d/%0d, need 1/1/0/0", miss3, dart_come3, dart_x3, dart_y3);
        end
        tick();
        checks++;
        if ({miss3, dart_come3} !== 2'b00) begin
            fails++;
            $display("FAIL timeout_pulse_width: miss/come got %b/%b, need 0/0", miss3, dart_come3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_turns();
        test_back_to_back();
        test_clamp();
        test_wrong_player();
        test_game_set();
        test_reset_mid();
`ifdef DART_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
